// File: rtl/uart_lite_core.sv
// UART 8N1 core behind the Wishbone UART adapter: data register at 00, status at 01.
// Define UART_RX_FIFO_EN to replace the single-byte receive register with an RX_FIFO_DEPTH FIFO.
module uart_lite_core #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  uart_addr_i,
    input  logic [31:0] uart_wdata_i,
    output logic [31:0] uart_rdata_o,
    input  logic        uart_we_i,
    input  logic        uart_sel_i,
    output logic        uart_tx_o,
    input  logic        uart_rx_i
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic        sel_q;
    logic        acc, wr_data, rd_data, rd_stat;
    logic [31:0] rdata_q, rmux;
    logic        unused_wdata;

    assign acc     = uart_sel_i & ~sel_q;
    assign wr_data = acc &  uart_we_i & (uart_addr_i == 2'b00);
    assign rd_data = acc & ~uart_we_i & (uart_addr_i == 2'b00);
    assign rd_stat = acc & ~uart_we_i & (uart_addr_i == 2'b01);
    assign unused_wdata = ^uart_wdata_i[31:8];

    // ---------------- transmitter ----------------
    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_baud_q, tx_baud_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
    logic        tx_full_q, tx_full_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        if (wr_data && !tx_full_q) begin
            tx_hold_d = uart_wdata_i[7:0];
            tx_full_d = 1'b1;
        end
        case (tx_state_q)
            S_IDLE: begin
                tx_baud_d = '0;
                if (tx_full_q) begin
                    tx_shift_d = tx_hold_q;
                    tx_full_d  = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_baud_q == BIT_LAST) begin
                    tx_baud_d = '0;
                    // Chain straight into the next start bit so queued frames have no idle gap.
                    if (tx_full_q) begin
                        tx_shift_d = tx_hold_q;
                        tx_full_d  = 1'b0;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        uart_tx_o = 1'b1;
        case (tx_state_q)
            S_START: uart_tx_o = 1'b0;
            S_DATA:  uart_tx_o = tx_shift_q[0];
            default: uart_tx_o = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_baud_q, rx_baud_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        push, frame_set;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push       = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_baud_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
            end
            S_START: begin
                if (rx_baud_q == HALF_LAST) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_baud_q == BIT_LAST) begin
                    rx_baud_d  = '0;
                    rx_state_d = S_IDLE;
                    push       = rx_s2_q;
                    frame_set  = ~rx_s2_q;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // ---------------- receive buffer ----------------
    logic       rx_valid, buf_full, pop, push_ok;
    logic [7:0] rx_data;
    logic       overrun_q, overrun_d, frame_err_q, frame_err_d;

    assign pop     = rd_data & rx_valid;
    assign push_ok = push & (~buf_full | pop);

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    logic [7:0]  fifo_mem [RX_FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;

    assign rx_valid = (wptr_q != rptr_q);
    assign buf_full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rx_data  = rx_valid ? fifo_mem[rptr_q[AW-1:0]] : 8'h00;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wptr_q[AW-1:0]] <= rx_shift_q;
    end
`else
    localparam int unused_fifo_depth = RX_FIFO_DEPTH;
    logic [7:0] rx_byte_q;
    logic       rx_full_q;

    assign rx_valid = rx_full_q;
    assign buf_full = rx_full_q;
    assign rx_data  = rx_full_q ? rx_byte_q : 8'h00;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_full_q <= 1'b0;
        end else if (push_ok) begin
            rx_full_q <= 1'b1;
        end else if (pop) begin
            rx_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) rx_byte_q <= rx_shift_q;
    end
`endif

    // A status read clears the sticky flags, but an error arriving on that same edge survives.
    always_comb begin
        overrun_d   = rd_stat ? 1'b0 : overrun_q;
        frame_err_d = rd_stat ? 1'b0 : frame_err_q;
        if (push && buf_full && !pop) overrun_d = 1'b1;
        if (frame_set) frame_err_d = 1'b1;
    end

    always_comb begin
        rmux = '0;
        case (uart_addr_i)
            2'b00:   rmux = {24'h0, rx_data};
            2'b01:   rmux = {28'h0, frame_err_q, overrun_q, tx_full_q, rx_valid};
            default: rmux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sel_q       <= 1'b0;
            rdata_q     <= '0;
            tx_state_q  <= S_IDLE;
            tx_baud_q   <= '0;
            tx_bit_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_baud_q   <= '0;
            rx_bit_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sel_q       <= uart_sel_i;
            if (acc) rdata_q <= rmux;
            tx_state_q  <= tx_state_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            tx_full_q   <= tx_full_d;
            rx_s1_q     <= uart_rx_i;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_bit_q    <= rx_bit_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tx_shift_q <= tx_shift_d;
        tx_hold_q  <= tx_hold_d;
        rx_shift_q <= rx_shift_d;
    end

    assign uart_rdata_o = rdata_q;
endmodule

// File: tb/tb_uart_lite_core.sv
// Directed bench for uart_lite_core at 8 clocks per bit; a background monitor decodes the TX line.
module tb_uart_lite_core;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst_n, sel, we, tx, rx;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mon_byte_q[$];
    logic       mon_stop_q[$];
    int         mon_start_q[$];

    uart_lite_core #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .uart_addr_i(addr), .uart_wdata_i(wdata),
        .uart_rdata_o(rdata), .uart_we_i(we), .uart_sel_i(sel),
        .uart_tx_o(tx), .uart_rx_i(rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Samples each serial bit near its centre; detection happens half a clock into the start bit.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       st;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_start_q.push_back(cyc);
                repeat (CPB / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                st = tx;
                mon_byte_q.push_back(b);
                mon_stop_q.push_back(st);
            end
        end
    end

    task automatic clear_mon();
        mon_byte_q.delete();
        mon_stop_q.delete();
        mon_start_q.delete();
    endtask

    task automatic bus(input logic [1:0] a, input logic w, input logic [7:0] d,
                       input int hold, output logic [31:0] rd);
        @(negedge clk);
        addr = a; we = w; wdata = {24'h0, d}; sel = 1'b1;
        repeat (hold) @(negedge clk);
        rd = rdata;
        sel = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (mon_byte_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (mon_byte_q.size() < n) begin
            errors++;
            $display("FAIL frame_wait: got %0d frames, expected %0d within %0d cycles",
                     mon_byte_q.size(), n, budget);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'b00; wdata = '0; rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", rd); end
    endtask

    task automatic test_tx_frame();
        logic [31:0] rd;
        logic [7:0]  b;
        clear_mon();
        bus(2'b00, 1'b1, 8'hA5, 3, rd);
        wait_frames(1, 300);
        repeat (100) @(negedge clk);
        checks++;
        if (mon_byte_q.size() !== 1) begin
            errors++; $display("FAIL tx_single_frame: got %0d frames expected 1", mon_byte_q.size());
        end
        b = (mon_byte_q.size() > 0) ? mon_byte_q[0] : 8'hxx;
        checks++;
        if (b !== 8'hA5) begin errors++; $display("FAIL tx_byte: got %h expected a5", b); end
        checks++;
        if (mon_stop_q.size() == 0 || mon_stop_q[0] !== 1'b1) begin
            errors++; $display("FAIL tx_stop: stop bit not 1");
        end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b expected 1", tx); end
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL tx_status_after: got %h expected 0", rd); end
    endtask

    task automatic test_tx_queue();
        logic [31:0] rd;
        logic [7:0]  b0, b1;
        int          gap;
        clear_mon();
        bus(2'b00, 1'b1, 8'h11, 1, rd);
        repeat (20) @(negedge clk);
        bus(2'b00, 1'b1, 8'h22, 1, rd);
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL txq_status_full: got %h expected 2", rd); end
        bus(2'b00, 1'b1, 8'h33, 1, rd);
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL txq_status_still_full: got %h expected 2", rd); end
        wait_frames(2, 400);
        repeat (150) @(negedge clk);
        checks++;
        if (mon_byte_q.size() !== 2) begin
            errors++; $display("FAIL txq_frame_count: got %0d expected 2", mon_byte_q.size());
        end
        b0 = (mon_byte_q.size() > 0) ? mon_byte_q[0] : 8'hxx;
        b1 = (mon_byte_q.size() > 1) ? mon_byte_q[1] : 8'hxx;
        checks++;
        if (b0 !== 8'h11) begin errors++; $display("FAIL txq_first: got %h expected 11", b0); end
        checks++;
        if (b1 !== 8'h22) begin errors++; $display("FAIL txq_second: got %h expected 22", b1); end
        gap = (mon_start_q.size() > 1) ? (mon_start_q[1] - mon_start_q[0]) : -1;
        checks++;
        if (gap !== 10 * CPB) begin
            errors++; $display("FAIL txq_back_to_back: start spacing %0d expected %0d", gap, 10 * CPB);
        end
    endtask

    task automatic test_rx_frame();
        logic [31:0] rd;
        send_rx(8'h3C, 1'b1);
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL rx_status: got %h expected 1", rd); end
        bus(2'b00, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h3C) begin errors++; $display("FAIL rx_data: got %h expected 3c", rd); end
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rx_status_empty: got %h expected 0", rd); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] rd;
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rx_glitch_status: got %h expected 0", rd); end
        send_rx(8'h55, 1'b0);
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h8) begin errors++; $display("FAIL rx_frame_err: got %h expected 8", rd); end
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rx_frame_err_clear: got %h expected 0", rd); end
        bus(2'b00, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rx_frame_err_data: got %h expected 0", rd); end
    endtask

`ifdef UART_RX_FIFO_EN
    task automatic test_rx_fifo();
        logic [31:0] rd;
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL fifo_status_overrun: got %h expected 5", rd); end
        for (int i = 1; i <= 4; i++) begin
            bus(2'b00, 1'b0, 8'h00, 1, rd);
            checks++;
            if (rd !== 32'(i)) begin errors++; $display("FAIL fifo_read_%0d: got %h expected %h", i, rd, i); end
        end
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL fifo_status_empty: got %h expected 0", rd); end
    endtask
`else
    task automatic test_rx_overrun();
        logic [31:0] rd;
        send_rx(8'hA1, 1'b1);
        send_rx(8'hB2, 1'b1);
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL ovr_status: got %h expected 5", rd); end
        bus(2'b00, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'hA1) begin errors++; $display("FAIL ovr_keeps_first: got %h expected a1", rd); end
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL ovr_status_clear: got %h expected 0", rd); end
    endtask
`endif

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic        stayed_idle;
        bus(2'b00, 1'b1, 8'h5A, 1, rd);
        repeat (10) @(negedge clk);
        bus(2'b00, 1'b1, 8'h6B, 1, rd);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b expected 1", tx); end
        rst_n = 1'b1;
        bus(2'b01, 1'b0, 8'h00, 1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midframe_reset_status: got %h expected 0", rd); end
        stayed_idle = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_idle = 1'b0;
        end
        checks++;
        if (stayed_idle !== 1'b1) begin
            errors++; $display("FAIL midframe_no_resume: tx left idle after reset, got %b expected 1", stayed_idle);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_tx_queue();
        test_rx_frame();
        test_rx_errors();
`ifdef UART_RX_FIFO_EN
        test_rx_fifo();
`else
        test_rx_overrun();
`endif
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
